obi_sram_arbiter: RTL
=====================

OBI_SRAM_ARBITER -- requirements
Module: obi_sram_arbiter

Interface
REQ-001 SHALL have parameter MAX_OUTSTANDING, default 2, meaning the maximum number of granted-but-unanswered transfers (legal range 1..4).
REQ-002 SHALL have parameter START_PRIO, default 0, meaning the manager that wins the first contended cycle after reset.
REQ-003 SHALL have a single clock clk_i and an asynchronous, active-low reset rst_ni: `clk_i  input  1  clock`; `rst_ni  input  1  async active-low reset`.
REQ-004 SHALL provide, for each manager n in {0,1}, the OBI subordinate-side ports below (manager 0 = core data port, manager 1 = debug/DMA host):
- mN_req_i  input  1  request
- mN_gnt_o  output  1  grant
- mN_addr_i  input  32  byte address
- mN_we_i  input  1  write enable
- mN_be_i  input  4  byte enables
- mN_wdata_i  input  32  write data
- mN_rvalid_o  output  1  response valid
- mN_rdata_o  output  32  read data
REQ-005 SHALL provide the following OBI manager-side ports toward the SRAM data port:
- s_req_o  output  1  request
- s_gnt_i  input  1  grant
- s_addr_o  output  32  address
- s_we_o  output  1  write enable
- s_be_o  output  4  byte enables
- s_wdata_o  output  32  write data
- s_rvalid_i  input  1  response valid
- s_rdata_i  input  32  read data
REQ-006 SHALL provide `protocol_err_o  output  1`, a sticky flag set by an unexpected s_rvalid_i.

Function
REQ-007 SHALL select one requesting manager per cycle combinationally: if only one manager requests, that manager wins; if both request, the manager not granted most recently wins (round-robin).
REQ-008 SHALL update the round-robin pointer only on a cycle where s_req_o && s_gnt_i; a request that is not granted SHALL NOT change priority.
REQ-009 SHALL drive s_req_o = (m0_req_i || m1_req_i) && !fifo_full, and SHALL drive s_addr_o, s_we_o, s_be_o and s_wdata_o from the selected manager; these outputs SHALL be zero when no manager is selected.
REQ-010 SHALL assert mN_gnt_o = s_gnt_i && s_req_o && (selected == N), with zero added latency; at most one of m0_gnt_o and m1_gnt_o SHALL be high in any cycle.
REQ-011 SHALL push the winning manager ID into an in-order ID FIFO on every s_req_o && s_gnt_i handshake.
REQ-012 SHALL, on s_rvalid_i, pop the FIFO head and assert mHEAD_rvalid_o with mHEAD_rdata_o = s_rdata_i in the same cycle; the other manager's rvalid and rdata SHALL be 0.
REQ-013 SHALL allow a push and a pop in the same cycle, including when the FIFO is full: count is unchanged and a new grant is allowed (no bubble).
REQ-014 SHALL gate s_req_o low when count == MAX_OUTSTANDING and no pop occurs this cycle, and SHALL NOT issue any grants while gated.
REQ-015 SHALL treat s_rvalid_i with an empty FIFO as follows: no manager rvalid, count unchanged, protocol_err_o set to 1 and held until reset.
REQ-016 SHALL keep the outstanding counter width equal to $clog2(MAX_OUTSTANDING+1); the counter SHALL never wrap.
REQ-017 SHALL NOT require the manager request signals to be held stable while ungranted; the arbiter re-evaluates every cycle.

Reset
REQ-018 SHALL, while rst_ni is low, asynchronously clear the FIFO, set count = 0, set the round-robin pointer so that START_PRIO wins next, and clear protocol_err_o; all gnt and rvalid outputs SHALL then be 0.
REQ-019 SHALL drop responses that were in flight when reset asserted; an s_rvalid_i arriving after reset release for a pre-reset grant SHALL be handled as in REQ-015.

Structure
REQ-020 SHALL place the mgr_id_e typedef (MGR_CORE = 0, MGR_HOST = 1) and the MAX_OUTSTANDING_LIMIT = 4 constant in the shared package sram_arb_pkg.
REQ-021 SHALL implement the ID FIFO as the sub-module sram_arb_id_fifo, with ports push, pop, din, dout, full, empty and count, built with a register array and a wrapping pointer.

Verification
REQ-022 Both managers request continuously with a 1-cycle-latency SRAM model -> grants alternate m0, m1, m0, m1, ... after reset, and each rvalid returns to the correct manager exactly one cycle after its grant.
REQ-023 With MAX_OUTSTANDING = 2 and the SRAM withholding rvalid for 3 cycles -> exactly 2 grants, then s_req_o stays 0 until the first rvalid arrives, after which a new grant is issued in that same cycle.
REQ-024 m1 writes 0xDEADBEEF with be = 0xF to 0x8000_0010, then m0 reads 0x8000_0010 -> m0_rdata_o = 0xDEADBEEF, and m1_rvalid_o pulses only for the write response.
REQ-025 s_rvalid_i pulsed with no outstanding transfer -> protocol_err_o = 1 and stays 1, both manager rvalid outputs stay 0, and it clears only on rst_ni.
REQ-026 rst_ni asserted with 2 transfers outstanding -> count = 0 immediately, and the first contended request after release is granted to START_PRIO.

Source files
------------

// File: rtl/sram_arb_pkg.sv
// rtl/sram_arb_pkg.sv - shared manager IDs and limits for the OBI SRAM arbiter
package sram_arb_pkg;

    localparam int MAX_OUTSTANDING_LIMIT = 4;

    typedef enum logic {
        MGR_CORE = 1'b0,
        MGR_HOST = 1'b1
    } mgr_id_e;

endpackage

// File: rtl/obi_sram_arbiter_if.sv
// rtl/obi_sram_arbiter_if.sv - one OBI link (request and response channels)
interface obi_sram_arbiter_if;

    logic        req;
    logic        gnt;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (
        output req, addr, we, be, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, addr, we, be, wdata,
        output gnt, rvalid, rdata
    );

endinterface

// File: rtl/sram_arb_id_fifo.sv
// rtl/sram_arb_id_fifo.sv - in-order FIFO of granted manager IDs awaiting a response
module sram_arb_id_fifo
    import sram_arb_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int CW    = $clog2(DEPTH + 1),
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          push,
    input  logic          pop,
    input  mgr_id_e       din,
    output mgr_id_e       dout,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    mgr_id_e       mem_q [DEPTH];
    mgr_id_e       mem_d [DEPTH];
    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign dout  = mem_q[rptr_q];

    // A push into a full FIFO is legal only when the head leaves in the same cycle.
    always_comb begin
        do_pop  = pop && !empty;
        do_push = push && (!full || do_pop);
        mem_d   = mem_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (do_push) begin
            mem_d[wptr_q] = din;
            wptr_d        = wrap_inc(wptr_q);
        end
        if (do_pop) begin
            rptr_d = wrap_inc(rptr_q);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= MGR_CORE;
            end
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            mem_q   <= mem_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/obi_sram_arbiter.sv
// rtl/obi_sram_arbiter.sv - two-manager round-robin OBI arbiter in front of one SRAM port
module obi_sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 2,
    parameter int START_PRIO      = 0
) (
    input  logic        clk_i,
    input  logic        rst_ni,

    input  logic        m0_req_i,
    output logic        m0_gnt_o,
    input  logic [31:0] m0_addr_i,
    input  logic        m0_we_i,
    input  logic [3:0]  m0_be_i,
    input  logic [31:0] m0_wdata_i,
    output logic        m0_rvalid_o,
    output logic [31:0] m0_rdata_o,

    input  logic        m1_req_i,
    output logic        m1_gnt_o,
    input  logic [31:0] m1_addr_i,
    input  logic        m1_we_i,
    input  logic [3:0]  m1_be_i,
    input  logic [31:0] m1_wdata_i,
    output logic        m1_rvalid_o,
    output logic [31:0] m1_rdata_o,

    output logic        s_req_o,
    input  logic        s_gnt_i,
    output logic [31:0] s_addr_o,
    output logic        s_we_o,
    output logic [3:0]  s_be_o,
    output logic [31:0] s_wdata_o,
    input  logic        s_rvalid_i,
    input  logic [31:0] s_rdata_i,

    output logic        protocol_err_o
);

    localparam int      CW       = $clog2(MAX_OUTSTANDING + 1);
    localparam mgr_id_e START_ID = (START_PRIO != 0) ? MGR_HOST : MGR_CORE;

    mgr_id_e       prio_q, prio_d;
    mgr_id_e       sel;
    mgr_id_e       head_id;
    logic          err_q, err_d;
    logic          any_req, hs, pop;
    logic          fifo_full, fifo_empty;
    logic [CW-1:0] outstanding;
    logic          unused_outstanding;

    assign unused_outstanding = ^outstanding;

    sram_arb_id_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_id_fifo (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .push   (hs),
        .pop    (pop),
        .din    (sel),
        .dout   (head_id),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .count  (outstanding)
    );

    always_comb begin
        any_req = m0_req_i || m1_req_i;
        if (m0_req_i && m1_req_i) begin
            sel = prio_q;
        end else if (m1_req_i) begin
            sel = MGR_HOST;
        end else begin
            sel = MGR_CORE;
        end

        // A response retiring this cycle frees a slot, so a full FIFO still grants.
        pop     = rst_ni && s_rvalid_i && !fifo_empty;
        s_req_o = rst_ni && any_req && (!fifo_full || pop);
        hs      = s_req_o && s_gnt_i;

        s_addr_o  = '0;
        s_we_o    = 1'b0;
        s_be_o    = '0;
        s_wdata_o = '0;
        if (any_req) begin
            if (sel == MGR_HOST) begin
                s_addr_o  = m1_addr_i;
                s_we_o    = m1_we_i;
                s_be_o    = m1_be_i;
                s_wdata_o = m1_wdata_i;
            end else begin
                s_addr_o  = m0_addr_i;
                s_we_o    = m0_we_i;
                s_be_o    = m0_be_i;
                s_wdata_o = m0_wdata_i;
            end
        end

        m0_gnt_o    = hs && (sel == MGR_CORE);
        m1_gnt_o    = hs && (sel == MGR_HOST);
        m0_rvalid_o = pop && (head_id == MGR_CORE);
        m1_rvalid_o = pop && (head_id == MGR_HOST);
        m0_rdata_o  = m0_rvalid_o ? s_rdata_i : '0;
        m1_rdata_o  = m1_rvalid_o ? s_rdata_i : '0;

        prio_d = prio_q;
        if (hs) begin
            prio_d = (sel == MGR_CORE) ? MGR_HOST : MGR_CORE;
        end
        err_d = err_q || (s_rvalid_i && fifo_empty);
    end

    assign protocol_err_o = err_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prio_q <= START_ID;
            err_q  <= 1'b0;
        end else begin
            prio_q <= prio_d;
            err_q  <= err_d;
        end
    end

endmodule
